// File: rtl/tick_scheduler.sv
// Runtime-programmable clock-enable scheduler: NCH divide channels emit one-cycle
// tick pulses in the in_clk domain, reconfigured one channel at a time over valid/ready.
module tick_scheduler #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CHAN_W      = 2,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHAN_W-1:0] cfg_chan,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic              cfg_err,
  input  logic              sync_all,
  output logic [NCH-1:0]    tick,
  output logic              busy
);

  // state | meaning
  // IDLE  | ready for a configuration request
  // APPLY | staged request is written to its channel on the exit edge
  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   ready_q, ready_d;
  logic   err_d;
  logic   accept;
  logic   apply_now;
  logic   chan_ok;

  logic [CHAN_W-1:0] stg_chan;
  logic [DIV_W-1:0]  stg_div;
  logic              stg_en;

  assign chan_ok   = (32'(stg_chan) < NCH);
  assign cfg_ready = ready_q;
  assign busy      = (state_q == APPLY);

  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    accept    = 1'b0;
    apply_now = 1'b0;
    case (state_q)
      IDLE: begin
        accept = cfg_valid && ready_q;
        if (accept) state_d = APPLY;
      end
      APPLY: begin
        apply_now = 1'b1;
        err_d     = !chan_ok;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // ready is registered so it stays low for the first cycle after reset release
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      cfg_err  <= 1'b0;
      stg_chan <= '0;
      stg_div  <= '0;
      stg_en   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cfg_err <= err_d;
      if (accept) begin
        stg_chan <= cfg_chan;
        stg_div  <= cfg_div;
        stg_en   <= cfg_en;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] divm1;
    logic             en_q;
    logic             tick_q;
    logic             hit;

    assign hit   = apply_now && chan_ok && (stg_chan == CHAN_W'(g));
    // div of 0 behaves as 1, so the terminal count never underflows
    assign divm1 = (div_q == '0) ? '0 : div_q - DIV_W'(1);

    always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
        cnt_q  <= '0;
        div_q  <= DIV_W'(DEFAULT_DIV);
        en_q   <= 1'b0;
        tick_q <= 1'b0;
      end else if (hit) begin
        div_q  <= stg_div;
        en_q   <= stg_en;
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else if (sync_all || !en_q) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else if (cnt_q == divm1) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + DIV_W'(1);
        tick_q <= 1'b0;
      end
    end

    assign tick[g] = tick_q;
  end

endmodule
